ucaspian_pkt_encoder: RTL and testbench
=======================================

# ucaspian_pkt_encoder

Downstream of `ucaspian_core`: turns the core's status and event outputs into a serial byte stream toward the host-link TX FIFO. The status outputs are output fires, time updates, metric reads, clear acks and config acks. Arbitrates among pending events, snapshots payloads, and emits fixed-format packets over a valid/ready byte interface. Returns the per-source completion strobes the core waits on.

## Interface
- Parameters: none. Packet formats and widths are fixed.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `output_fire_addr`  in  8  fired output neuron; valid while `output_fire_waiting`.
- `output_fire_waiting`  in  1  level request; held until `output_fire_sent`.
- `output_fire_sent`  out  1  one-cycle completion strobe for fire.
- `time_current`  in  32  core time; sampled at packet start.
- `time_update`  in  1  level request; held until `time_sent`.
- `time_sent`  out  1  one-cycle completion strobe for time.
- `metric_value`  in  8  metric byte; valid only in the `metric_send` cycle.
- `metric_send`  in  1  single-cycle pulse.
- `clear_done`  in  1  level request; held until `ack_sent`.
- `ack_sent`  out  1  one-cycle completion strobe for clear ack.
- `config_done`  in  1  config ack; each rising edge is one event.
- `tx_data`  out  8  byte to TX FIFO.
- `tx_vld`  out  1  byte valid.
- `tx_rdy`  in  1  FIFO accepts; a transfer occurs when `tx_vld && tx_rdy`.
- `busy`  out  1  high when the FSM is not in IDLE.
- `metric_overrun`  out  1  sticky flag: `metric_send` arrived while a metric was pending; cleared only by reset.

## Operation
- Packet formats (opcode first, multi-byte fields MSB first):
  - CLEAR_ACK `0x01`, 1 byte.
  - CONFIG_ACK `0x02`, 1 byte.
  - METRIC `0x03, value`, 2 bytes.
  - TIME `0x05, t[31:24], t[23:16], t[15:8], t[7:0]`, 5 bytes.
  - FIRE `0x04, addr`, 2 bytes.
- Fixed priority, evaluated only in IDLE: CLEAR > CONFIG > METRIC > TIME > FIRE.
  - TIME outranks FIRE so that a step's time report precedes fires of the next step.
- Metric latch:
  - On `metric_send`, latch `metric_value` and set `metric_pend`.
  - If `metric_pend` is already set, overwrite the value and set `metric_overrun`.
  - `metric_pend` clears when the METRIC packet's last byte is accepted.
- Config counter:
  - 8-bit `cfg_pend`. +1 on a `config_done` rising edge (prior-cycle register); −1 when a CONFIG_ACK packet completes.
  - Both in the same cycle: value unchanged.
  - Saturates at 255 (increment dropped); never underflows.
- FSM states:
  - IDLE: select the highest-priority request. Snapshot opcode, length and payload (`time_current`, `output_fire_addr` or metric latch) into a 5-byte shift buffer. Go to SEND with byte index 0.
  - SEND: drive the buffered byte with `tx_vld`=1. On transfer, advance the index. On transfer of the last byte, go to DONE.
  - DONE: one cycle. Pulse the strobe for the served level source (`ack_sent`, `time_sent` or `output_fire_sent`); METRIC and CONFIG have no strobe. Then go to IDLE.
- DONE exists so the core sees the strobe and drops its level request before IDLE re-samples it. Requests must not be double-served.
- Payload is frozen at snapshot. Later changes to `time_current` or `output_fire_addr` do not affect the packet in flight.
- `tx_data` is stable and `tx_vld` held while `tx_rdy`=0. `tx_vld` is never withdrawn before transfer.

## Timing
- Reset values:
  - `tx_vld`=0, `tx_data`=0x00.
  - All strobes 0, `busy`=0, `metric_overrun`=0.
  - `metric_pend`=0, `cfg_pend`=0, edge-detect register 0.
  - FSM in IDLE.
- Reset mid-packet: the packet is abandoned with no strobe, and the next cycle shows `tx_vld`=0.
- Latency: request visible in IDLE at cycle c gives first byte with `tx_vld`=1 at c+1.
- With `tx_rdy` held high, an N-byte packet occupies SEND for N cycles, then DONE strobe at c+N+1, then IDLE at c+N+2.
- Back-to-back packets: N+2 cycles each.
- `config_done` high for several cycles counts once per rising edge. A `metric_send` arriving during any state is captured.
- Requests arriving during SEND/DONE wait for IDLE and are not lost.

## Test plan
- Single fire: `output_fire_addr`=0x2A, waiting=1, `tx_rdy`=1 → bytes 0x04, 0x2A on consecutive cycles; `output_fire_sent` pulses 1 cycle; no second FIRE packet.
- Time with backpressure: `time_current`=0x01020304, `time_update`=1, `tx_rdy` toggled 1/0 → bytes 0x05,01,02,03,04 with `tx_data` stable during stalls; `time_current` changed mid-packet does not alter the bytes; `time_sent` pulses once.
- Priority: `clear_done`, `time_update`, `output_fire_waiting` raised together, each held until strobed → packet order 0x01 / 0x05.. / 0x04..; strobes in the same order.
- Config counting: three `config_done` rising edges during a 5-byte TIME packet → exactly three 0x02 packets afterwards; `cfg_pend` returns to 0.
- Metric: `metric_send` pulse with value 0x11, then a second pulse with 0x22 before service → one METRIC packet `0x03, 0x22`; `metric_overrun`=1.
- Reset at byte index 2 of a TIME packet → next cycle `tx_vld`=0, no `time_sent`; a held `time_update` causes a full fresh TIME packet after reset.

Source files
------------

// File: rtl/ucaspian_pkt_encoder.sv
// Packet encoder between ucaspian_core status/event outputs and the host-link TX FIFO.
// Arbitrates pending events in IDLE, snapshots the payload, and streams it over a valid/ready byte port.
//
// state | meaning
// IDLE  | waiting for a request; highest-priority one is snapshotted into the shift buffer
// SEND  | presenting buffered bytes on tx_data/tx_vld until the last one is accepted
// DONE  | one-cycle completion strobe for the served level source
module ucaspian_pkt_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  output_fire_addr,
    input  logic        output_fire_waiting,
    output logic        output_fire_sent,
    input  logic [31:0] time_current,
    input  logic        time_update,
    output logic        time_sent,
    input  logic [7:0]  metric_value,
    input  logic        metric_send,
    input  logic        clear_done,
    output logic        ack_sent,
    input  logic        config_done,
    output logic [7:0]  tx_data,
    output logic        tx_vld,
    input  logic        tx_rdy,
    output logic        busy,
    output logic        metric_overrun
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;
    typedef enum logic [2:0] {SRC_CLEAR, SRC_CONFIG, SRC_METRIC, SRC_TIME, SRC_FIRE} src_t;

    state_t      state_q, state_d;
    src_t        src_q, src_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  len_q, len_d;
    logic [39:0] buf_q, buf_d;
    logic [7:0]  metric_val_q, metric_val_d;
    logic        metric_pend_q, metric_pend_d;
    logic        metric_new_q, metric_new_d;
    logic        metric_overrun_q, metric_overrun_d;
    logic [7:0]  cfg_pend_q, cfg_pend_d;
    logic        cfg_done_prev_q, cfg_done_prev_d;

    logic xfer;
    logic last_xfer;
    logic snap_metric;
    logic cfg_rise;
    logic cfg_fin;
    logic met_fin;

    assign xfer      = (state_q == ST_SEND) && tx_rdy;
    assign last_xfer = xfer && (idx_q == (len_q - 3'd1));
    assign cfg_rise  = config_done && !cfg_done_prev_q;
    assign cfg_fin   = last_xfer && (src_q == SRC_CONFIG);
    assign met_fin   = last_xfer && (src_q == SRC_METRIC);

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        idx_d       = idx_q;
        len_d       = len_q;
        buf_d       = buf_q;
        snap_metric = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_SEND;
                idx_d   = 3'd0;
                if (clear_done) begin
                    src_d = SRC_CLEAR;
                    len_d = 3'd1;
                    buf_d = {8'h01, 32'h0};
                end else if (cfg_pend_q != 8'd0) begin
                    src_d = SRC_CONFIG;
                    len_d = 3'd1;
                    buf_d = {8'h02, 32'h0};
                end else if (metric_pend_q) begin
                    src_d       = SRC_METRIC;
                    len_d       = 3'd2;
                    buf_d       = {8'h03, metric_val_q, 24'h0};
                    snap_metric = 1'b1;
                end else if (time_update) begin
                    src_d = SRC_TIME;
                    len_d = 3'd5;
                    buf_d = {8'h05, time_current};
                end else if (output_fire_waiting) begin
                    src_d = SRC_FIRE;
                    len_d = 3'd2;
                    buf_d = {8'h04, output_fire_addr, 24'h0};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    buf_d = {buf_q[31:0], 8'h00};
                    idx_d = idx_q + 3'd1;
                    if (last_xfer) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A metric arriving after the snapshot keeps metric_pend set past the current packet.
    always_comb begin
        metric_val_d     = metric_send ? metric_value : metric_val_q;
        metric_new_d     = metric_send ? 1'b1 : (snap_metric ? 1'b0 : metric_new_q);
        metric_pend_d    = metric_send ? 1'b1 : (met_fin ? metric_new_q : metric_pend_q);
        metric_overrun_d = metric_overrun_q | (metric_send & metric_pend_q);
        cfg_done_prev_d  = config_done;
        cfg_pend_d       = cfg_pend_q;
        if (cfg_rise && !cfg_fin && (cfg_pend_q != 8'hFF)) begin
            cfg_pend_d = cfg_pend_q + 8'd1;
        end else if (cfg_fin && !cfg_rise && (cfg_pend_q != 8'h00)) begin
            cfg_pend_d = cfg_pend_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            src_q            <= SRC_CLEAR;
            idx_q            <= 3'd0;
            len_q            <= 3'd0;
            buf_q            <= 40'h0;
            metric_val_q     <= 8'h00;
            metric_pend_q    <= 1'b0;
            metric_new_q     <= 1'b0;
            metric_overrun_q <= 1'b0;
            cfg_pend_q       <= 8'h00;
            cfg_done_prev_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            src_q            <= src_d;
            idx_q            <= idx_d;
            len_q            <= len_d;
            buf_q            <= buf_d;
            metric_val_q     <= metric_val_d;
            metric_pend_q    <= metric_pend_d;
            metric_new_q     <= metric_new_d;
            metric_overrun_q <= metric_overrun_d;
            cfg_pend_q       <= cfg_pend_d;
            cfg_done_prev_q  <= cfg_done_prev_d;
        end
    end

    assign tx_vld           = (state_q == ST_SEND);
    assign tx_data          = (state_q == ST_SEND) ? buf_q[39:32] : 8'h00;
    assign busy             = (state_q != ST_IDLE);
    assign ack_sent         = (state_q == ST_DONE) && (src_q == SRC_CLEAR);
    assign time_sent        = (state_q == ST_DONE) && (src_q == SRC_TIME);
    assign output_fire_sent = (state_q == ST_DONE) && (src_q == SRC_FIRE);
    assign metric_overrun   = metric_overrun_q;

endmodule

// File: tb/tb_ucaspian_pkt_encoder.sv
// Bench for ucaspian_pkt_encoder: directed scenarios plus random traffic against a
// packet-queue reference model, with a core emulation that drops level requests on their strobe.
module tb_ucaspian_pkt_encoder;

    logic        clk;
    logic        reset;
    logic [7:0]  output_fire_addr;
    logic        output_fire_waiting;
    logic        output_fire_sent;
    logic [31:0] time_current;
    logic        time_update;
    logic        time_sent;
    logic [7:0]  metric_value;
    logic        metric_send;
    logic        clear_done;
    logic        ack_sent;
    logic        config_done;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic        busy;
    logic        metric_overrun;

    ucaspian_pkt_encoder dut (
        .clk                 (clk),
        .reset               (reset),
        .output_fire_addr    (output_fire_addr),
        .output_fire_waiting (output_fire_waiting),
        .output_fire_sent    (output_fire_sent),
        .time_current        (time_current),
        .time_update         (time_update),
        .time_sent           (time_sent),
        .metric_value        (metric_value),
        .metric_send         (metric_send),
        .clear_done          (clear_done),
        .ack_sent            (ack_sent),
        .config_done         (config_done),
        .tx_data             (tx_data),
        .tx_vld              (tx_vld),
        .tx_rdy              (tx_rdy),
        .busy                (busy),
        .metric_overrun      (metric_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         strobes[$];
    int         exp_s[$];

    // Reference model: phase 0 idle, 1 sending, 2 strobe cycle; kind 0 clear,1 cfg,2 metric,3 time,4 fire
    int          m_phase;
    int          m_kind;
    logic [7:0]  m_q[$];
    int unsigned m_cfg_edges, m_cfg_served;
    bit          m_cfg_prev;
    int unsigned m_met_arr, m_met_snap, m_met_done;
    logic [7:0]  m_met_val;
    bit          m_ovr;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_kind = 0; m_q.delete();
        m_cfg_edges = 0; m_cfg_served = 0; m_cfg_prev = 0;
        m_met_arr = 0; m_met_snap = 0; m_met_done = 0; m_met_val = 8'h00; m_ovr = 0;
    endtask

    task automatic model_start(input int kind, input int n, input logic [39:0] bytes);
        m_kind  = kind;
        m_phase = 1;
        m_q.delete();
        for (int i = 0; i < n; i++) m_q.push_back(bytes[39 - 8*i -: 8]);
    endtask

    task automatic model_step();
        int unsigned cfg_pend;
        bit met_pend, cfg_fin, met_fin, rise;
        if (reset) begin
            model_reset();
            return;
        end
        cfg_pend = m_cfg_edges - m_cfg_served;
        met_pend = (m_met_arr != m_met_done);
        cfg_fin  = 0;
        met_fin  = 0;
        case (m_phase)
            0: begin
                if (clear_done) model_start(0, 1, {8'h01, 32'h0});
                else if (cfg_pend != 0) model_start(1, 1, {8'h02, 32'h0});
                else if (met_pend) begin
                    model_start(2, 2, {8'h03, m_met_val, 24'h0});
                    m_met_snap = m_met_arr;
                end
                else if (time_update) model_start(3, 5, {8'h05, time_current});
                else if (output_fire_waiting) model_start(4, 2, {8'h04, output_fire_addr, 24'h0});
            end
            1: if (tx_rdy) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_phase = 2;
                    cfg_fin = (m_kind == 1);
                    met_fin = (m_kind == 2);
                end
            end
            default: m_phase = 0;
        endcase
        if (met_fin) m_met_done = m_met_snap;
        if (metric_send) begin
            if (met_pend) m_ovr = 1;
            m_met_val = metric_value;
            m_met_arr++;
        end
        rise = config_done && !m_cfg_prev;
        m_cfg_prev = config_done;
        if (cfg_fin) m_cfg_served++;
        if (rise && !(cfg_pend == 255 && !cfg_fin)) m_cfg_edges++;
    endtask

    // One clock: record any transfer, advance the model, then compare at the falling edge.
    task automatic tick();
        logic [7:0] e_data;
        if (!reset && tx_vld && tx_rdy) got.push_back(tx_data);
        model_step();
        @(negedge clk);
        e_data = (m_phase == 1) ? m_q[0] : 8'h00;
        check_eq("tx_vld", tx_vld, (m_phase == 1));
        check_eq("tx_data", tx_data, e_data);
        check_eq("busy", busy, (m_phase != 0));
        check_eq("ack_sent", ack_sent, (m_phase == 2 && m_kind == 0));
        check_eq("time_sent", time_sent, (m_phase == 2 && m_kind == 3));
        check_eq("fire_sent", output_fire_sent, (m_phase == 2 && m_kind == 4));
        check_eq("metric_overrun", metric_overrun, m_ovr);
        if (ack_sent) begin clear_done = 0; strobes.push_back(1); end
        if (time_sent) begin time_update = 0; strobes.push_back(2); end
        if (output_fire_sent) begin output_fire_waiting = 0; strobes.push_back(3); end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_bytes(input string tag);
        check_eq({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check_eq(tag, got[i], exp_q[i]);
        got.delete();
    endtask

    task automatic check_strobes(input string tag);
        check_eq({tag, "_cnt"}, strobes.size(), exp_s.size());
        for (int i = 0; i < exp_s.size() && i < strobes.size(); i++)
            check_eq(tag, strobes[i], exp_s[i]);
        strobes.delete();
    endtask

    initial begin
        reset = 1; tx_rdy = 0;
        output_fire_addr = 0; output_fire_waiting = 0; time_current = 0; time_update = 0;
        metric_value = 0; metric_send = 0; clear_done = 0; config_done = 0;
        model_reset();
        @(negedge clk);
        run(2);
        check_eq("rst_tx_vld", tx_vld, 0);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overrun", metric_overrun, 0);
        reset = 0;
        run(2);
        got.delete(); strobes.delete();

        // single fire
        tx_rdy = 1; output_fire_addr = 8'h2A; output_fire_waiting = 1;
        run(10);
        exp_q = {8'h04, 8'h2A}; check_bytes("fire_bytes");
        exp_s = {3}; check_strobes("fire_strobe");

        // time with backpressure and payload change mid-packet
        time_current = 32'h01020304; time_update = 1;
        for (int i = 0; i < 20; i++) begin
            tx_rdy = i[0];
            if (i == 3) time_current = 32'hDEADBEEF;
            tick();
        end
        exp_q = {8'h05, 8'h01, 8'h02, 8'h03, 8'h04}; check_bytes("time_bytes");
        exp_s = {2}; check_strobes("time_strobe");

        // priority
        tx_rdy = 1; time_current = 32'hCAFE0102; output_fire_addr = 8'h77;
        clear_done = 1; time_update = 1; output_fire_waiting = 1;
        run(25);
        exp_q = {8'h01, 8'h05, 8'hCA, 8'hFE, 8'h01, 8'h02, 8'h04, 8'h77}; check_bytes("prio_bytes");
        exp_s = {1, 2, 3}; check_strobes("prio_strobes");

        // config edges during a TIME packet
        time_current = 32'h10203040; time_update = 1;
        tick();
        for (int i = 0; i < 6; i++) begin config_done = ~i[0]; tick(); end
        config_done = 0;
        run(25);
        exp_q = {8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h02, 8'h02, 8'h02}; check_bytes("cfg_bytes");
        strobes.delete();

        // metric overwrite while busy
        tx_rdy = 0; time_current = 32'h00000009; time_update = 1;
        tick();
        metric_value = 8'h11; metric_send = 1; tick();
        metric_send = 0; tick();
        metric_value = 8'h22; metric_send = 1; tick();
        metric_send = 0; tx_rdy = 1;
        run(20);
        exp_q = {8'h05, 8'h00, 8'h00, 8'h00, 8'h09, 8'h03, 8'h22}; check_bytes("metric_bytes");
        check_eq("metric_overrun_set", metric_overrun, 1);
        strobes.delete();

        // reset at byte index 2 of a TIME packet
        time_current = 32'hA1B2C3D4; time_update = 1;
        run(3);
        check_eq("pre_rst_byte2", tx_data, 8'hB2);
        reset = 1; tick();
        check_eq("mid_rst_vld", tx_vld, 0);
        check_eq("mid_rst_overrun", metric_overrun, 0);
        reset = 0; got.delete();
        run(15);
        exp_q = {8'h05, 8'hA1, 8'hB2, 8'hC3, 8'hD4}; check_bytes("rst_time_bytes");
        exp_s = {2}; check_strobes("rst_time_strobe");

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            tx_rdy = ($urandom_range(0, 9) < 7);
            if (!clear_done && $urandom_range(0, 39) == 0) clear_done = 1;
            if (!time_update && $urandom_range(0, 11) == 0) time_update = 1;
            if (!output_fire_waiting && $urandom_range(0, 5) == 0) output_fire_waiting = 1;
            if ($urandom_range(0, 3) == 0) output_fire_addr = 8'($urandom);
            if ($urandom_range(0, 3) == 0) time_current = $urandom;
            metric_send = ($urandom_range(0, 24) == 0);
            metric_value = 8'($urandom);
            if ($urandom_range(0, 7) == 0) config_done = ~config_done;
            reset = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset = 0; metric_send = 0;
        run(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
